pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq_if.sv | 30 +++
 rtl/pc_seq.sv | 106 ++++++++++
 tb/tb_pc_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// Control/status bundle between a sequencer client (master) and pc_seq (slave).
interface pc_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned SpW = $clog2(DEPTH + 1);

    logic             stall;
    logic [2:0]       op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic             clr_err;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] ret_addr;
    logic [SpW-1:0]   sp;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf;
    logic             unf;

    modport master (
        output stall, op, target, offset, clr_err,
        input  pc_out, ret_addr, sp, stack_full, stack_empty, ovf, unf
    );

    modport slave (
        input  stall, op, target, offset, clr_err,
        output pc_out, ret_addr, sp, stack_full, stack_empty, ovf, unf
    );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: INC/JMP/BR/CALL/RET/HOLD with a bounded return stack
// and sticky overflow/underflow flags.
module pc_seq #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic     clk,
    input logic     rst,
    pc_seq_if.slave bus
);
    localparam int unsigned    SpW    = $clog2(DEPTH + 1);
    localparam int unsigned    IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

    typedef enum logic [2:0] {
        OpInc  = 3'b000,
        OpJmp  = 3'b001,
        OpBr   = 3'b010,
        OpCall = 3'b011,
        OpRet  = 3'b100,
        OpHold = 3'b101
    } op_e;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, top;
    logic [SpW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             full, empty, push;
    logic [IdxW-1:0]  top_idx, push_idx;
    op_e              op;

    assign op       = op_e'(bus.op);
    assign full     = (sp_q == SpFull);
    assign empty    = (sp_q == '0);
    assign pc_inc   = pc_q + 1'b1;
    assign top_idx  = IdxW'(sp_q - 1'b1);
    assign push_idx = IdxW'(sp_q);
    // Gate on empty so stale storage behind sp never leaks out.
    assign top      = empty ? '0 : stack_q[top_idx];

    always_comb begin
        pc_d  = pc_inc;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        // Flag sets below come after the clear so a same-cycle set wins.
        case (op)
            OpJmp:  pc_d = bus.target;
            OpBr:   pc_d = pc_q + bus.offset;
            OpCall: begin
                if (!full) begin
                    push = 1'b1;
                    sp_d = sp_q + 1'b1;
                    pc_d = bus.target;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            OpRet: begin
                if (!empty) begin
                    pc_d = top;
                    sp_d = sp_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            OpHold: pc_d = pc_q;
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is deliberately left unreset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !bus.stall) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.sp          = sp_q;
    assign bus.ret_addr    = top;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf         = ovf_q;
    assign bus.unf         = unf_q;
endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq (WIDTH=8, DEPTH=4, RESET_VECTOR=0) using a scoreboard queue.
module tb_pc_seq;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BR   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HOLD = 3'b101;
    localparam logic [2:0] OP_RSVD = 3'b110;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] tgt;
        logic [7:0] off;
        logic       st;
        logic       clr;
        logic [7:0] pc;
        logic [2:0] sp;
        logic       ovf;
        logic       unf;
        logic [7:0] ret;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    step_t sb[$];

    always #5 clk = ~clk;

    pc_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(8'h00)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic step_t mk(input logic [2:0] op, input logic [7:0] tgt, input logic [7:0] off,
                                 input logic st, input logic clr, input logic [7:0] pc,
                                 input logic [2:0] sp, input logic ovf, input logic unf,
                                 input logic [7:0] ret);
        step_t s;
        s = '{op: op, tgt: tgt, off: off, st: st, clr: clr, pc: pc, sp: sp, ovf: ovf, unf: unf,
              ret: ret};
        return s;
    endfunction

    task automatic drive(input step_t s);
        bus.op      = s.op;
        bus.target  = s.tgt;
        bus.offset  = s.off;
        bus.stall   = s.st;
        bus.clr_err = s.clr;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step_t e;
        // Drive a stalled CALL while in reset: reset must override everything.
        drive(mk(OP_CALL, 8'h77, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00));
        rst = 1'b1;
        sb.push_back(mk(OP_INC, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                sb.push_back(mk(OP_INC, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00));
                @(posedge clk);
            end
            #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.pc_out !== e.pc || bus.sp !== e.sp || bus.ovf !== e.ovf || bus.unf !== e.unf ||
                bus.ret_addr !== e.ret || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got pc=%h sp=%0d ovf=%b unf=%b ret=%h empty=%b, want pc=%h sp=%0d ovf=%b unf=%b ret=%h empty=1",
                         i, bus.pc_out, bus.sp, bus.ovf, bus.unf, bus.ret_addr, bus.stack_empty,
                         e.pc, e.sp, e.ovf, e.unf, e.ret);
            end
        end
        rst = 1'b0;
    endtask

    task automatic run_steps(input string name, input step_t t[$]);
        step_t e;
        foreach (t[i]) begin
            drive(t[i]);
            sb.push_back(t[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.pc_out !== e.pc || bus.sp !== e.sp || bus.ovf !== e.ovf || bus.unf !== e.unf ||
                bus.ret_addr !== e.ret || bus.stack_empty !== (e.sp == 3'd0) ||
                bus.stack_full !== (e.sp == 3'd4)) begin
                n_fail++;
                $display("FAIL %s[%0d]: got pc=%h sp=%0d ovf=%b unf=%b ret=%h full=%b empty=%b, want pc=%h sp=%0d ovf=%b unf=%b ret=%h",
                         name, i, bus.pc_out, bus.sp, bus.ovf, bus.unf, bus.ret_addr,
                         bus.stack_full, bus.stack_empty, e.pc, e.sp, e.ovf, e.unf, e.ret);
            end
        end
    endtask

    task automatic test_inc();
        step_t t[$];
        t.push_back(mk(OP_INC, 8'h00, 8'h00, 0, 0, 8'h01, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_INC, 8'h00, 8'h00, 0, 0, 8'h02, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_INC, 8'h00, 8'h00, 0, 0, 8'h03, 3'd0, 0, 0, 8'h00));
        run_steps("inc", t);
    endtask

    task automatic test_branch();
        step_t t[$];
        t.push_back(mk(OP_JMP, 8'h10, 8'h00, 0, 0, 8'h10, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_BR,  8'h00, 8'hF0, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_BR,  8'h00, 8'h05, 0, 0, 8'h05, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_JMP, 8'hFF, 8'h00, 0, 0, 8'hFF, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_INC, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_HOLD, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00));
        run_steps("branch", t);
    endtask

    task automatic test_call_ret();
        step_t t[$];
        t.push_back(mk(OP_JMP,  8'h05, 8'h00, 0, 0, 8'h05, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_CALL, 8'h40, 8'h00, 0, 0, 8'h40, 3'd1, 0, 0, 8'h06));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 8'h06, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_RSVD, 8'h99, 8'h00, 0, 0, 8'h07, 3'd0, 0, 0, 8'h00));
        run_steps("call_ret", t);
    endtask

    task automatic test_nested();
        step_t t[$];
        pulse_reset();
        t.push_back(mk(OP_CALL, 8'h20, 8'h00, 0, 0, 8'h20, 3'd1, 0, 0, 8'h01));
        t.push_back(mk(OP_CALL, 8'h30, 8'h00, 0, 0, 8'h30, 3'd2, 0, 0, 8'h21));
        t.push_back(mk(OP_CALL, 8'h40, 8'h00, 0, 0, 8'h40, 3'd3, 0, 0, 8'h31));
        t.push_back(mk(OP_CALL, 8'h50, 8'h00, 0, 0, 8'h50, 3'd4, 0, 0, 8'h41));
        t.push_back(mk(OP_CALL, 8'h60, 8'h00, 0, 0, 8'h51, 3'd4, 1, 0, 8'h41));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 8'h41, 3'd3, 1, 0, 8'h31));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 8'h31, 3'd2, 1, 0, 8'h21));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 8'h21, 3'd1, 1, 0, 8'h01));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 8'h01, 3'd0, 1, 0, 8'h00));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 8'h02, 3'd0, 1, 1, 8'h00));
        run_steps("nested", t);
    endtask

    task automatic test_stall_clr();
        step_t t[$];
        t.push_back(mk(OP_JMP,  8'h80, 8'h00, 1, 0, 8'h02, 3'd0, 1, 1, 8'h00));
        t.push_back(mk(OP_JMP,  8'h80, 8'h00, 1, 1, 8'h02, 3'd0, 1, 1, 8'h00));
        t.push_back(mk(OP_CALL, 8'h80, 8'h00, 1, 1, 8'h02, 3'd0, 1, 1, 8'h00));
        t.push_back(mk(OP_HOLD, 8'h00, 8'h00, 0, 1, 8'h02, 3'd0, 0, 0, 8'h00));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 1, 8'h03, 3'd0, 0, 1, 8'h00));
        t.push_back(mk(OP_CALL, 8'h70, 8'h00, 0, 1, 8'h70, 3'd1, 0, 0, 8'h04));
        t.push_back(mk(OP_CALL, 8'h90, 8'h00, 1, 0, 8'h70, 3'd1, 0, 0, 8'h04));
        t.push_back(mk(OP_RET,  8'h00, 8'h00, 1, 0, 8'h70, 3'd1, 0, 0, 8'h04));
        run_steps("stall_clr", t);
    endtask

    task automatic test_async_reset();
        step_t t[$];
        step_t e;
        pulse_reset();
        t.push_back(mk(OP_CALL, 8'h10, 8'h00, 0, 0, 8'h10, 3'd1, 0, 0, 8'h01));
        t.push_back(mk(OP_CALL, 8'h32, 8'h00, 0, 0, 8'h32, 3'd2, 0, 0, 8'h11));
        t.push_back(mk(OP_INC,  8'h00, 8'h00, 0, 0, 8'h33, 3'd2, 0, 0, 8'h11));
        run_steps("async_pre", t);
        // Assert reset mid-cycle and check before any further clock edge.
        #3;
        rst = 1'b1;
        sb.push_back(mk(OP_INC, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0, 8'h00));
        #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.pc_out !== e.pc || bus.sp !== e.sp || bus.ret_addr !== e.ret ||
            bus.stack_empty !== 1'b1 || bus.ovf !== e.ovf || bus.unf !== e.unf) begin
            n_fail++;
            $display("FAIL async_reset: got pc=%h sp=%0d ret=%h empty=%b ovf=%b unf=%b, want pc=%h sp=%0d ret=%h empty=1",
                     bus.pc_out, bus.sp, bus.ret_addr, bus.stack_empty, bus.ovf, bus.unf,
                     e.pc, e.sp, e.ret);
        end
        rst = 1'b0;
        t.delete();
        t.push_back(mk(OP_RET, 8'h00, 8'h00, 0, 0, 8'h01, 3'd0, 0, 1, 8'h00));
        run_steps("async_post", t);
    endtask

    initial begin
        test_reset();
        test_inc();
        test_branch();
        test_call_ret();
        test_nested();
        test_stall_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
